dmem_bist: RTL and testbench

Built-in self-test initiator for the processor data memory. While the core is held off, it drives the memory's address, write-data and write-enable lines, runs a March C- style sequence across every word, and compares read data. It reports pass/fail with the first failing address and phase. It sits between the datapath and the data memory and takes over the memory port through `mem_sel`.

---
 rtl/dmem_bist.sv | 182 ++++++++++++++++++
 tb/tb_dmem_bist.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bist.sv
// March C- built-in self-test initiator for the processor data memory.
// Optional checkerboard phases are enabled by defining DMEM_BIST_CKBD_EN.
module dmem_bist #(
  parameter int DEPTH = 100,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_sel,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_phase
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_END
  } state_t;

`ifdef DMEM_BIST_CKBD_EN
  localparam logic [2:0] LAST_PHASE = 3'd5;
`else
  localparam logic [2:0] LAST_PHASE = 3'd3;
`endif
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [DW-1:0] CK_EVEN   = DW'(32'hAAAA_AAAA);
  localparam logic [DW-1:0] CK_ODD    = DW'(32'h5555_5555);

  state_t          r_state, w_stateNxt;
  logic [2:0]      r_phase, w_phaseNxt;
  logic [AW-1:0]   r_addr, w_addrNxt;
  logic            r_done, w_doneNxt;
  logic            r_pass, w_passNxt;
  logic [AW-1:0]   r_failAddr, w_failAddrNxt;
  logic [2:0]      r_failPhase, w_failPhaseNxt;

  logic            w_run;
  logic            w_we;
  logic            w_cmpEn;
  logic            w_desc;
  logic [DW-1:0]   w_wd;
  logic [DW-1:0]   w_exp;
  logic [DW-1:0]   w_ckbd;
  logic            w_mismatch;
  logic            w_lastAddr;
  logic [2:0]      w_phaseInc;

  assign w_run  = (r_state == S_RUN);
  assign w_ckbd = r_addr[0] ? CK_ODD : CK_EVEN;

  // Per-phase memory operation: what to write and what the old contents must be.
  always_comb begin
    w_we    = 1'b0;
    w_cmpEn = 1'b0;
    w_desc  = 1'b0;
    w_wd    = '0;
    w_exp   = '0;
    case (r_phase)
      3'd0: begin
        w_we = 1'b1;
      end
      3'd1: begin
        w_cmpEn = 1'b1;
        w_we    = 1'b1;
        w_wd    = '1;
      end
      3'd2: begin
        w_cmpEn = 1'b1;
        w_exp   = '1;
        w_we    = 1'b1;
        w_desc  = 1'b1;
      end
      3'd3: begin
        w_cmpEn = 1'b1;
      end
`ifdef DMEM_BIST_CKBD_EN
      3'd4: begin
        w_we = 1'b1;
        w_wd = w_ckbd;
      end
      3'd5: begin
        w_cmpEn = 1'b1;
        w_exp   = w_ckbd;
      end
`endif
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  assign w_mismatch = w_run && w_cmpEn && (mem_rd != w_exp);
  assign w_lastAddr = w_desc ? (r_addr == '0) : (r_addr == ADDR_LAST);
  assign w_phaseInc = r_phase + 3'd1;

  always_comb begin
    w_stateNxt     = r_state;
    w_phaseNxt     = r_phase;
    w_addrNxt      = r_addr;
    w_doneNxt      = r_done;
    w_passNxt      = r_pass;
    w_failAddrNxt  = r_failAddr;
    w_failPhaseNxt = r_failPhase;
    case (r_state)
      S_IDLE, S_END: begin
        if (start) begin
          w_stateNxt     = S_RUN;
          w_phaseNxt     = 3'd0;
          w_addrNxt      = '0;
          w_doneNxt      = 1'b0;
          w_passNxt      = 1'b0;
          w_failAddrNxt  = '0;
          w_failPhaseNxt = 3'd0;
        end
      end
      S_RUN: begin
        if (w_mismatch) begin
          w_stateNxt     = S_END;
          w_doneNxt      = 1'b1;
          w_passNxt      = 1'b0;
          w_failAddrNxt  = r_addr;
          w_failPhaseNxt = r_phase;
        end else if (w_lastAddr) begin
          if (r_phase == LAST_PHASE) begin
            w_stateNxt = S_END;
            w_doneNxt  = 1'b1;
            w_passNxt  = 1'b1;
          end else begin
            w_phaseNxt = w_phaseInc;
            // Only the R1W0 phase walks downward, so it starts at the top word.
            w_addrNxt  = (w_phaseInc == 3'd2) ? ADDR_LAST : '0;
          end
        end else begin
          w_addrNxt = w_desc ? (r_addr - AW'(1)) : (r_addr + AW'(1));
        end
      end
      default: begin
        w_stateNxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= 3'd0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_failAddr  <= '0;
      r_failPhase <= 3'd0;
    end else begin
      r_state     <= w_stateNxt;
      r_phase     <= w_phaseNxt;
      r_addr      <= w_addrNxt;
      r_done      <= w_doneNxt;
      r_pass      <= w_passNxt;
      r_failAddr  <= w_failAddrNxt;
      r_failPhase <= w_failPhaseNxt;
    end
  end

  assign mem_sel    = w_run;
  assign busy       = w_run;
  assign mem_a      = w_run ? r_addr : '0;
  assign mem_wd     = w_run ? w_wd : '0;
  assign mem_we     = w_run & w_we;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_addr  = r_failAddr;
  assign fail_phase = r_failPhase;

endmodule

// File: tb/tb_dmem_bist.sv
// Directed self-checking bench for dmem_bist with a behavioural memory that can
// inject a stuck-at bit (word 17, bit 3) or an address alias (99 onto 98).
module tb_dmem_bist;

   localparam int DEPTH = 100;
   localparam int AW    = 32;
   localparam int DW    = 32;
`ifdef DMEM_BIST_CKBD_EN
   localparam int RUN_LEN = 6 * DEPTH;
`else
   localparam int RUN_LEN = 4 * DEPTH;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mem_sel;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic          mem_we;
   logic [DW-1:0] mem_rd;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_phase;

   logic          scramble;
   logic          stuckEn;
   logic          aliasEn;
   logic [31:0]   mem [0:DEPTH-1];
   int            rdIdx;
   int            wrIdx;
   logic [31:0]   wrData;

   int testCount = 0;
   int failCount = 0;
   int cyc;
   int nonZero;

   dmem_bist #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_sel    (mem_sel),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_addr  (fail_addr),
      .fail_phase (fail_phase)
   );

   always #5 clk = ~clk;

   // Combinational read path of the memory model, including the alias fault.
   always_comb begin
      rdIdx = int'(mem_a);
      if (aliasEn && mem_a == 32'd99) rdIdx = 98;
      mem_rd = (rdIdx < DEPTH) ? mem[rdIdx] : 32'h0;
   end

   // Write path: the stuck-at cell never stores a 1 in bit 3.
   always_comb begin
      wrIdx  = int'(mem_a);
      if (aliasEn && mem_a == 32'd99) wrIdx = 98;
      wrData = mem_wd;
      if (stuckEn && mem_a == 32'd17) wrData[3] = 1'b0;
   end

   // Scramble preloads junk so the W0 phase has to really clear every word.
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_BEEF ^ i;
      end else if (mem_we && wrIdx < DEPTH) begin
         mem[wrIdx] <= wrData;
      end
   end

   // Counts the comparison and reports any mismatch with the observed and required values.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Pulses start so it is sampled at the next rising edge (edge 0); returns #1 after it.
   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after edge 0 until done rises, optionally re-pulsing start at cycles 10 and 200.
   task automatic waitDone(input int limit, input bit repulse, output int cycles);
      cycles = 0;
      while (!done && cycles < limit) begin
         @(posedge clk);
         #1;
         cycles++;
         if (repulse) start = (cycles == 9 || cycles == 199);
      end
      start = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      scramble = 1'b1;
      stuckEn  = 1'b0;
      aliasEn  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      scramble = 1'b0;
      checkOutput("rst mem_sel", mem_sel, 0);
      checkOutput("rst mem_a", mem_a, 0);
      checkOutput("rst mem_wd", mem_wd, 0);
      checkOutput("rst mem_we", mem_we, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst pass", pass, 0);
      checkOutput("rst fail_addr", fail_addr, 0);
      checkOutput("rst fail_phase", fail_phase, 0);
      @(negedge clk);
      rst = 1'b0;

      // Fault-free run.
      applyStimulus();
      checkOutput("run busy", busy, 1);
      checkOutput("run mem_sel", mem_sel, 1);
      checkOutput("run first addr", mem_a, 0);
      checkOutput("run first we", mem_we, 1);
      waitDone(RUN_LEN + 10, 1'b0, cyc);
      checkOutput("pass cycles", cyc, RUN_LEN);
      checkOutput("pass done", done, 1);
      checkOutput("pass busy", busy, 0);
      checkOutput("pass pass", pass, 1);
      checkOutput("pass fail_addr", fail_addr, 0);
      checkOutput("pass fail_phase", fail_phase, 0);
`ifdef DMEM_BIST_CKBD_EN
      checkOutput("ckbd word4", mem[4], 32'hAAAA_AAAA);
      checkOutput("ckbd word5", mem[5], 32'h5555_5555);
`else
      nonZero = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h0) nonZero++;
      checkOutput("mem all zero", nonZero, 0);
`endif

      // Stuck-at 0 on bit 3 of word 17: caught on the descending R1W0 pass.
      stuckEn = 1'b1;
      applyStimulus();
      checkOutput("restart clears pass", pass, 0);
      checkOutput("restart clears done", done, 0);
      waitDone(RUN_LEN + 10, 1'b0, cyc);
      checkOutput("stuck cycles", cyc, 283);
      checkOutput("stuck done", done, 1);
      checkOutput("stuck pass", pass, 0);
      checkOutput("stuck fail_addr", fail_addr, 17);
      checkOutput("stuck fail_phase", fail_phase, 2);
      stuckEn = 1'b0;

      // Word 99 aliased onto 98: reading 99 returns the ones just written to 98.
      aliasEn = 1'b1;
      applyStimulus();
      checkOutput("restart clears fail_addr", fail_addr, 0);
      checkOutput("restart clears fail_phase", fail_phase, 0);
      waitDone(RUN_LEN + 10, 1'b0, cyc);
      checkOutput("alias cycles", cyc, 200);
      checkOutput("alias pass", pass, 0);
      checkOutput("alias fail_addr", fail_addr, 99);
      checkOutput("alias fail_phase", fail_phase, 1);
      aliasEn = 1'b0;

      // Reset mid-run at cycle 150 (phase R0W1, so writes are active).
      applyStimulus();
      repeat (149) @(posedge clk);
      #2;
      checkOutput("pre-rst we", mem_we, 1);
      rst = 1'b1;
      #1;
      checkOutput("mid-rst we", mem_we, 0);
      checkOutput("mid-rst mem_sel", mem_sel, 0);
      checkOutput("mid-rst busy", busy, 0);
      checkOutput("mid-rst done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus();
      waitDone(RUN_LEN + 10, 1'b0, cyc);
      checkOutput("post-rst cycles", cyc, RUN_LEN);
      checkOutput("post-rst pass", pass, 1);

      // Start re-pulsed during RUN is ignored.
      applyStimulus();
      waitDone(RUN_LEN + 10, 1'b1, cyc);
      checkOutput("repulse cycles", cyc, RUN_LEN);
      checkOutput("repulse pass", pass, 1);

      // Start while in END restarts the test.
      applyStimulus();
      checkOutput("end restart done", done, 0);
      checkOutput("end restart busy", busy, 1);
      waitDone(RUN_LEN + 10, 1'b0, cyc);
      checkOutput("end restart cycles", cyc, RUN_LEN);
      checkOutput("end restart pass", pass, 1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
